stream_minmax_tracker: RTL and testbench

- Downstream consumer of the N-bit magnitude comparison: takes a framed stream of unsigned N-bit samples and tracks the running maximum and minimum over each frame.
- Uses greater/equal/lesser decisions internally.
- Reports max, min, their first-occurrence indices and the sample count once per frame.
- Has a valid/ready handshake on both sides.
- Sits between a sample source (ADC/test pattern) and a host-side result register/FIFO.

---
 rtl/stream_minmax_tracker.sv | 147 ++++++++++++++
 tb/tb_stream_minmax_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stream_minmax_tracker.sv
// Framed stream min/max tracker: reports max, min, first-occurrence indices and
// sample count once per frame, with valid/ready handshakes on input and output.
module stream_minmax_tracker #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_max,
    output logic [N-1:0]     out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [N-1:0]     max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_max_q, out_max_d, out_min_q, out_min_d;
    logic [CNT_W-1:0] out_max_idx_q, out_max_idx_d;
    logic [CNT_W-1:0] out_min_idx_q, out_min_idx_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic accept, capture, is_gt, is_lt;

    assign accept = in_valid && in_ready_q;
    assign is_gt  = in_data > max_q;
    assign is_lt  = in_data < min_q;

    always_comb begin
        state_d       = state_q;
        max_d         = max_q;
        min_d         = min_q;
        max_idx_d     = max_idx_q;
        min_idx_d     = min_idx_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_max_d     = out_max_q;
        out_min_d     = out_min_q;
        out_max_idx_d = out_max_idx_q;
        out_min_idx_d = out_min_idx_q;
        out_count_d   = out_count_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    max_d     = in_data;
                    min_d     = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    capture   = in_last;
                    state_d   = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    // Strict compares: equal samples keep the first occurrence.
                    if (is_gt) begin
                        max_d     = in_data;
                        max_idx_d = cnt_q;
                    end
                    if (is_lt) begin
                        min_d     = in_data;
                        min_idx_d = cnt_q;
                    end
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    capture = in_last;
                    if (in_last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            out_valid_d   = 1'b1;
            out_max_d     = max_d;
            out_min_d     = min_d;
            out_max_idx_d = max_idx_d;
            out_min_idx_d = min_idx_d;
            out_count_d   = cnt_d;
        end

        in_ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            max_q         <= '0;
            min_q         <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_max_q     <= '0;
            out_min_q     <= '0;
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
            out_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            max_q         <= max_d;
            min_q         <= min_d;
            max_idx_q     <= max_idx_d;
            min_idx_q     <= min_idx_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_max_q     <= out_max_d;
            out_min_q     <= out_min_d;
            out_max_idx_q <= out_max_idx_d;
            out_min_idx_q <= out_min_idx_d;
            out_count_q   <= out_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_max     = out_max_q;
    assign out_min     = out_min_q;
    assign out_max_idx = out_max_idx_q;
    assign out_min_idx = out_min_idx_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed bench for stream_minmax_tracker: a default instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=3) receive the same stimulus.
module tb_stream_minmax_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       a_in_ready, a_out_valid;
    logic [7:0] a_max, a_min, a_max_idx, a_min_idx, a_count;
    logic       b_in_ready, b_out_valid;
    logic [7:0] b_max, b_min;
    logic [2:0] b_max_idx, b_min_idx, b_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_minmax_tracker #(.N(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_max(a_max), .out_min(a_min),
        .out_max_idx(a_max_idx), .out_min_idx(a_min_idx), .out_count(a_count)
    );

    stream_minmax_tracker #(.N(8), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_max(b_max), .out_min(b_min),
        .out_max_idx(b_max_idx), .out_min_idx(b_min_idx), .out_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int waited = 0;
        while (!a_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("send_ready_a", a_in_ready, 1);
        chk("send_ready_b", b_in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic check_a(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                           input logic [7:0] mxi, input logic [7:0] mni, input logic [7:0] c);
        chk({tag, "_a_valid"}, a_out_valid, 1);
        chk({tag, "_a_max"}, a_max, mx);
        chk({tag, "_a_min"}, a_min, mn);
        chk({tag, "_a_max_idx"}, a_max_idx, mxi);
        chk({tag, "_a_min_idx"}, a_min_idx, mni);
        chk({tag, "_a_count"}, a_count, c);
    endtask

    task automatic check_b(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                           input logic [2:0] mxi, input logic [2:0] mni, input logic [2:0] c);
        chk({tag, "_b_valid"}, b_out_valid, 1);
        chk({tag, "_b_max"}, b_max, mx);
        chk({tag, "_b_min"}, b_min, mn);
        chk({tag, "_b_max_idx"}, b_max_idx, mxi);
        chk({tag, "_b_min_idx"}, b_min_idx, mni);
        chk({tag, "_b_count"}, b_count, c);
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, a_out_valid, 0);
        chk({tag, "_valid_drop_b"}, b_out_valid, 0);
        chk({tag, "_ready_back"}, a_in_ready, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_max", a_max, 0);
        chk("rst_min", a_min, 0);
        chk("rst_max_idx", a_max_idx, 0);
        chk("rst_min_idx", a_min_idx, 0);
        chk("rst_count", a_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", a_in_ready, 1);

        // 1: 5,9,2,9,2 with out_ready held high
        out_ready = 1'b1;
        send(8'd5, 0); send(8'd9, 0); send(8'd2, 0); send(8'd9, 0); send(8'd2, 1);
        check_a("t1", 8'd9, 8'd2, 8'd1, 8'd2, 8'd5);
        check_b("t1", 8'd9, 8'd2, 3'd1, 3'd2, 3'd5);
        chk("t1_in_ready_low", a_in_ready, 0);
        @(negedge clk);
        chk("t1_valid_drop", a_out_valid, 0);
        chk("t1_in_ready_back", a_in_ready, 1);
        out_ready = 1'b0;

        // 2: single sample, consumer stalls 4 cycles
        send(8'hA5, 1);
        for (int i = 0; i < 5; i++) begin
            check_a("t2", 8'hA5, 8'hA5, 8'd0, 8'd0, 8'd1);
            chk("t2_in_ready_low", a_in_ready, 0);
            if (i == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("t2_valid_drop", a_out_valid, 0);
        chk("t2_max_kept", a_max, 8'hA5);
        chk("t2_count_kept", a_count, 1);

        // out_ready outside HOLD does nothing
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ack_valid", a_out_valid, 0);
        chk("idle_ack_ready", a_in_ready, 1);

        // 3: samples with in_valid gaps
        send(8'h00, 0);
        repeat (2) @(negedge clk);
        send(8'hFF, 0);
        @(negedge clk);
        send(8'h80, 1);
        check_a("t3", 8'hFF, 8'h00, 8'd1, 8'd0, 8'd3);
        check_b("t3", 8'hFF, 8'h00, 3'd1, 3'd0, 3'd3);
        ack("t3");

        // 4: all-equal frame
        send(8'd7, 0); send(8'd7, 0); send(8'd7, 0); send(8'd7, 1);
        check_a("t4", 8'd7, 8'd7, 8'd0, 8'd0, 8'd4);
        check_b("t4", 8'd7, 8'd7, 3'd0, 3'd0, 3'd4);
        ack("t4");

        // 5: 1..10 saturates the narrow counter at 7
        for (int v = 1; v <= 10; v++) send(8'(v), v == 10);
        check_a("t5", 8'd10, 8'd1, 8'd9, 8'd0, 8'd10);
        check_b("t5", 8'd10, 8'd1, 3'd7, 3'd0, 3'd7);
        ack("t5");

        // 6: reset mid-frame aborts it
        send(8'd3, 0); send(8'd4, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_valid", a_out_valid, 0);
        chk("t6_rst_in_ready", a_in_ready, 0);
        chk("t6_rst_max", a_max, 0);
        chk("t6_rst_count", a_count, 0);
        @(negedge clk);
        chk("t6_no_result", a_out_valid, 0);
        send(8'd6, 0); send(8'd1, 1);
        check_a("t6", 8'd6, 8'd1, 8'd0, 8'd1, 8'd2);
        check_b("t6", 8'd6, 8'd1, 3'd0, 3'd1, 3'd2);

        // reset while holding a result
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("hold_rst_valid", a_out_valid, 0);
        chk("hold_rst_min", a_min, 0);
        chk("hold_rst_count_b", b_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
